// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU that sits between register-file read and writeback.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, ADC, reserved) finish on the accept edge.
// MUL is an iterative shift-add multiply that takes WIDTH extra cycles.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset_n    - asynchronous active-low reset
//   in_valid   - operand/op bundle valid
//   in_ready   - block can accept a bundle this cycle
//   ALUControl - operation select (000 ADD, 001 SUB, 010 AND, 011 OR,
//                100 XOR, 101 ADC, 110 MUL, 111 reserved)
//   a, b       - operands
//   carry_in   - carry input, used by ADC only
//   out_valid  - Result/ALUFlags valid
//   out_ready  - downstream accepts the result
//   Result     - registered result
//   ALUFlags   - registered {N, Z, C, V}
//   busy       - multiply in progress
module alu_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             busy
);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StMulBusy = 1'b1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpAdc = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic             accept, consume;
    logic [WIDTH-1:0] b_op;
    logic             cin_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] op_res;
    logic             op_c, op_v, is_mul;
    logic [3:0]       op_flags;
    logic [WIDTH-1:0] acc_step;

    // Output slot must be empty or draining this edge before a new bundle is taken.
    assign in_ready  = reset_n && (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid_q && out_ready;
    assign busy      = (state_q == StMulBusy);
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign ALUFlags  = flags_q;

    // Single-cycle datapath
    always_comb begin
        b_op   = (ALUControl == OpSub) ? ~b : b;
        cin_op = (ALUControl == OpSub) || ((ALUControl == OpAdc) && carry_in);
        sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_op};
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        is_mul = 1'b0;
        case (ALUControl)
            OpAdd, OpSub, OpAdc: begin
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpAnd:   op_res = a & b;
            OpOr:    op_res = a | b;
            OpXor:   op_res = a ^ b;
            OpMul:   is_mul = MUL_EN;
            // Reserved (and MUL when disabled): zero result gives flags 4'b0100.
            default: op_res = '0;
        endcase
        op_flags = {op_res[WIDTH-1], (op_res == '0), op_c, op_v};
    end

    // One shift-add step; the product is taken modulo 2^WIDTH.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = CntInit;
                        state_d  = StMulBusy;
                    end else begin
                        result_d    = op_res;
                        flags_d     = op_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMulBusy: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CntOne;
                // Last step: publish the updated accumulator on this same edge.
                if (cnt_q == CntOne) begin
                    result_d    = acc_step;
                    flags_d     = {acc_step[WIDTH-1], (acc_step == '0), 2'b00};
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe: a WIDTH=32 instance for single-cycle ops,
// backpressure, streaming and reset, and a WIDTH=8 instance for MUL.
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=32 instance
    logic        iv, irdy, cin, ov, ordy, bsy;
    logic [2:0]  ctl;
    logic [31:0] a, b, res;
    logic [3:0]  flg;

    // WIDTH=8 instance
    logic        iv8, irdy8, cin8, ov8, ordy8, bsy8;
    logic [2:0]  ctl8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  flg8;

    int n_cmp = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) u_dut32 (
        .clk        (clk),
        .reset_n    (rst_n),
        .in_valid   (iv),
        .in_ready   (irdy),
        .ALUControl (ctl),
        .a          (a),
        .b          (b),
        .carry_in   (cin),
        .out_valid  (ov),
        .out_ready  (ordy),
        .Result     (res),
        .ALUFlags   (flg),
        .busy       (bsy)
    );

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) u_dut8 (
        .clk        (clk),
        .reset_n    (rst_n),
        .in_valid   (iv8),
        .in_ready   (irdy8),
        .ALUControl (ctl8),
        .a          (a8),
        .b          (b8),
        .carry_in   (cin8),
        .out_valid  (ov8),
        .out_ready  (ordy8),
        .Result     (res8),
        .ALUFlags   (flg8),
        .busy       (bsy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle to the 32-bit instance and hold it for exactly the accept edge.
    task automatic send32(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                          input logic xc, input string tag);
        ctl = op;
        a   = xa;
        b   = xb;
        cin = xc;
        iv  = 1'b1;
        #1;
        chk({tag, " in_ready"}, {31'd0, irdy}, 32'd1);
        step();
        iv = 1'b0;
    endtask

    task automatic mul8(input logic [7:0] xa, input logic [7:0] xb, input logic [7:0] exp_r,
                        input logic [3:0] exp_f, input string tag);
        int lat;
        int bcnt;
        ctl8 = 3'b110;
        a8   = xa;
        b8   = xb;
        iv8  = 1'b1;
        step();
        iv8  = 1'b0;
        // Operands change while busy; they must not be sampled.
        a8   = ~xa;
        b8   = 8'h55;
        ctl8 = 3'b000;
        chk({tag, " in_ready busy"}, {31'd0, irdy8}, 32'd0);
        lat  = 1;
        bcnt = 0;
        while (!ov8 && lat < 30) begin
            if (bsy8) bcnt++;
            step();
            lat++;
        end
        chk({tag, " latency"}, lat, 32'd9);
        chk({tag, " busy cycles"}, bcnt, 32'd8);
        chk({tag, " result"}, {24'd0, res8}, {24'd0, exp_r});
        chk({tag, " flags"}, {28'd0, flg8}, {28'd0, exp_f});
        chk({tag, " busy done"}, {31'd0, bsy8}, 32'd0);
    endtask

    logic [2:0]  s_op [4];
    logic [31:0] s_a  [4];
    logic [31:0] s_b  [4];
    logic [31:0] s_r  [4];
    logic [3:0]  s_f  [4];
    logic        seen_ov;

    initial begin
        rst_n = 1'b0;
        iv = 1'b0; ctl = 3'd0; a = '0; b = '0; cin = 1'b0; ordy = 1'b1;
        iv8 = 1'b0; ctl8 = 3'd0; a8 = '0; b8 = '0; cin8 = 1'b0; ordy8 = 1'b1;
        #1;
        chk("reset result", res, 32'd0);
        chk("reset flags", {28'd0, flg}, 32'd0);
        chk("reset out_valid", {31'd0, ov}, 32'd0);
        chk("reset busy", {31'd0, bsy}, 32'd0);
        chk("reset in_ready", {31'd0, irdy}, 32'd0);
        chk("reset out_valid8", {31'd0, ov8}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("post-reset in_ready", {31'd0, irdy}, 32'd1);

        // Arithmetic flags
        send32(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add ovf");
        chk("add ovf result", res, 32'h8000_0000);
        chk("add ovf flags", {28'd0, flg}, 32'h9);
        chk("add ovf out_valid", {31'd0, ov}, 32'd1);
        send32(3'b001, 32'd5, 32'd5, 1'b0, "sub eq");
        chk("sub eq result", res, 32'd0);
        chk("sub eq flags", {28'd0, flg}, 32'h6);
        send32(3'b001, 32'd3, 32'd5, 1'b0, "sub borrow");
        chk("sub borrow result", res, 32'hFFFF_FFFE);
        chk("sub borrow flags", {28'd0, flg}, 32'h8);
        send32(3'b101, 32'hFFFF_FFFF, 32'd0, 1'b1, "adc");
        chk("adc result", res, 32'd0);
        chk("adc flags", {28'd0, flg}, 32'h6);
        send32(3'b000, 32'hFFFF_FFFF, 32'd0, 1'b1, "add cin");
        chk("add cin result", res, 32'hFFFF_FFFF);
        chk("add cin flags", {28'd0, flg}, 32'h8);
        step();
        chk("drain out_valid", {31'd0, ov}, 32'd0);

        // Backpressure
        ordy = 1'b0;
        send32(3'b100, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, "xor");
        ctl = 3'b010; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; iv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp in_ready", {31'd0, irdy}, 32'd0);
            chk("bp out_valid", {31'd0, ov}, 32'd1);
            chk("bp result", res, 32'h5A5A_5A5A);
            chk("bp flags", {28'd0, flg}, 32'h0);
            step();
        end
        ordy = 1'b1;
        #1;
        chk("bp release in_ready", {31'd0, irdy}, 32'd1);
        step();
        iv = 1'b0;
        chk("bp new result", res, 32'hF000_F000);
        chk("bp new flags", {28'd0, flg}, 32'h8);
        chk("bp new out_valid", {31'd0, ov}, 32'd1);

        // Streaming, one result per cycle
        s_op[0] = 3'b010; s_a[0] = 32'h1234_5678; s_b[0] = 32'h0000_FFFF;
        s_r[0] = 32'h0000_5678; s_f[0] = 4'h0;
        s_op[1] = 3'b010; s_a[1] = 32'hFFFF_0000; s_b[1] = 32'h0000_FFFF;
        s_r[1] = 32'h0000_0000; s_f[1] = 4'h4;
        s_op[2] = 3'b011; s_a[2] = 32'h0F0F_0000; s_b[2] = 32'h0000_0F0F;
        s_r[2] = 32'h0F0F_0F0F; s_f[2] = 4'h0;
        s_op[3] = 3'b011; s_a[3] = 32'h8000_0000; s_b[3] = 32'h0000_0001;
        s_r[3] = 32'h8000_0001; s_f[3] = 4'h8;
        iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ctl = s_op[i]; a = s_a[i]; b = s_b[i];
            #1;
            chk("stream in_ready", {31'd0, irdy}, 32'd1);
            step();
            chk("stream result", res, s_r[i]);
            chk("stream flags", {28'd0, flg}, {28'd0, s_f[i]});
            chk("stream out_valid", {31'd0, ov}, 32'd1);
        end
        iv = 1'b0;
        step();
        chk("stream drain", {31'd0, ov}, 32'd0);

        // Multiply on the 8-bit instance
        mul8(8'h10, 8'h11, 8'h10, 4'h0, "mul 10x11");
        mul8(8'h0F, 8'h0F, 8'hE1, 4'h8, "mul 0Fx0F");

        // Reset during a 32-bit multiply
        send32(3'b110, 32'd3, 32'd5, 1'b0, "mul32");
        repeat (9) step();
        chk("mid-mul busy", {31'd0, bsy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async result", res, 32'd0);
        chk("async flags", {28'd0, flg}, 32'd0);
        chk("async out_valid", {31'd0, ov}, 32'd0);
        chk("async busy", {31'd0, bsy}, 32'd0);
        chk("async in_ready", {31'd0, irdy}, 32'd0);
        step();
        #2 rst_n = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen_ov = seen_ov | ov;
        end
        chk("no spurious out_valid", {31'd0, seen_ov}, 32'd0);
        chk("post-release in_ready", {31'd0, irdy}, 32'd1);
        send32(3'b111, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, "reserved");
        chk("reserved result", res, 32'd0);
        chk("reserved flags", {28'd0, flg}, 32'h4);
        chk("reserved out_valid", {31'd0, ov}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Adds XOR, add-with-carry and an iterative shift-add multiply, with valid/ready handshakes on input and output.
- Sits between the register-file read stage and writeback; the downstream stage can stall it.
- Flags keep the ARM NZCV convention: {N, Z, C, V}.

Parameters:
- WIDTH, 32, datapath width in bits (≥ 4).
- MUL_EN, 1, 1 = MUL op implemented; 0 = MUL opcode treated as reserved.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/op bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- ALUControl  in  3  operation select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry input, used by ADC only.
- out_valid  out  1  Result/ALUFlags valid.
- out_ready  in  1  downstream accepts the result.
- Result  out  WIDTH  registered result.
- ALUFlags  out  4  registered {N, Z, C, V}.
- busy  out  1  multiply in progress.

Behaviour:
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 ADC: a+b+carry_in.
  - 110 MUL: low WIDTH bits of a*b.
  - 111 reserved.
- Arithmetic flags (ADD/SUB/ADC):
  - sum is computed WIDTH+1 bits wide; C = bit WIDTH.
  - SUB: C=1 means no borrow.
  - V = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), where b' is b for ADD/ADC and ~b for SUB.
- Logic ops and MUL: C=0, V=0.
- All ops: N = Result[W-1]; Z = (Result == 0).
- Reserved op (or MUL with MUL_EN=0): Result=0, ALUFlags=4'b0100, single-cycle.
- Reset (reset_n low, async):
  - State goes to IDLE.
  - out_valid=0, Result=0, ALUFlags=0, busy=0.
  - in_ready=0 while reset_n is low.
  - An in-flight multiply is discarded; nothing is emitted after reset release.
- FSM states: IDLE, MUL_BUSY.
  - in_ready = reset_n && state==IDLE && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
- IDLE, accept, single-cycle op: Result/ALUFlags/out_valid=1 load on the same edge. Latency 1 cycle.
- IDLE, accept, MUL:
  - Latch a (multiplicand) and b (multiplier).
  - Clear the accumulator and set the counter to WIDTH.
  - Go to MUL_BUSY; busy=1.
- MUL_BUSY, each cycle:
  - If multiplier[0]=1, acc += multiplicand (mod 2^WIDTH).
  - multiplicand <<= 1; multiplier >>= 1; counter -= 1.
  - When the counter reaches 0: load Result=acc and flags, set out_valid=1, return to IDLE, drop busy.
  - Accept-to-out_valid latency is WIDTH+1 cycles.
  - No early termination.
- Output handshake:
  - A result is consumed on out_valid && out_ready.
  - Result/ALUFlags are held stable while out_valid && !out_ready.
  - out_valid clears on consume unless a new bundle is accepted on the same edge.
  - Accept and consume on the same edge is allowed (back-to-back throughput 1/cycle for single-cycle ops). The new single-cycle result replaces the old one; out_valid stays 1.
- MUL completion while the previous result is still unconsumed cannot occur: acceptance requires the output to be free or draining.
- in_valid is ignored when in_ready=0. The sender must hold its bundle until accepted.
- Inputs are sampled only on accept. Changes to a/b/ALUControl during MUL_BUSY have no effect.

Test Plan:
- Overflow and borrow, WIDTH=32:
  - ADD a=0x7FFFFFFF, b=0x00000001 → Result 0x80000000, ALUFlags 4'b1001 one cycle after accept.
  - SUB a=5, b=5 → Result 0, ALUFlags 4'b0110.
  - SUB a=3, b=5 → Result 0xFFFFFFFE, ALUFlags 4'b1000.
- ADC, WIDTH=32: a=0xFFFFFFFF, b=0, carry_in=1 → Result 0, ALUFlags 4'b0110.
  - Same operands with ADD and carry_in=1 → Result 0xFFFFFFFF, ALUFlags 4'b1000 (carry_in ignored).
- MUL, WIDTH=8:
  - a=0x10, b=0x11 → busy high 8 cycles, out_valid on cycle 9 after accept, Result 0x10, ALUFlags 4'b0000.
  - a=0x0F, b=0x0F → Result 0xE1, ALUFlags 4'b1000.
- Backpressure: XOR a=0xA5A5A5A5, b=0xFFFFFFFF with out_ready=0 for 5 cycles → Result 0x5A5A5A5A, ALUFlags 4'b0000.
  - Output held stable throughout; in_ready=0 throughout.
  - Raising out_ready with a new bundle presented → consume and accept on the same edge.
- Streaming: 4 back-to-back AND/OR ops with out_ready=1 → one result per cycle, in order, no bubbles.
- Reset mid-MUL, WIDTH=32: assert reset_n=0 at cycle 10 of MUL_BUSY.
  - Result 0, ALUFlags 0, out_valid 0, busy 0 immediately (asynchronous).
  - After release: in_ready=1 and no spurious out_valid.
  - Reserved op 111 afterwards → Result 0, ALUFlags 4'b0100.
